// File: rtl/demux_8bit_1x4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshaking and one holding register per channel.
// Optional per-channel transfer counters are enabled by defining DEMUX_8BIT_XFER_CNT_EN.
module demux_8bit_1x4_reg #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic                busy
`ifdef DEMUX_8BIT_XFER_CNT_EN
    ,
    output logic [4*CNT_W-1:0]  xfer_cnt
`endif
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic [3:0]        state;
    logic [3:0]        load;
    logic [3:0]        drain;
    logic              accept;
    logic [DATA_W-1:0] data_q [4];

    // Only the selected channel's ready bit reaches in_ready, so a stalled
    // consumer cannot hold off words bound elsewhere.
    assign in_ready = (state[in_sel] == ST_EMPTY) || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        load  = '0;
        drain = '0;
        for (int k = 0; k < 4; k++) begin
            load[k]  = accept && (in_sel == 2'(k));
            drain[k] = (state[k] == ST_FULL) && out_ready[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= {4{ST_EMPTY}};
        end else begin
            for (int k = 0; k < 4; k++) begin
                case (state[k])
                    ST_EMPTY: if (load[k])  state[k] <= ST_FULL;
                    ST_FULL:  if (drain[k] && !load[k]) state[k] <= ST_EMPTY;
                    default:  state[k] <= ST_EMPTY;
                endcase
            end
        end
    end

    // NOTE: the holding registers are reset because out_data must read zero after reset;
    // they are otherwise written only on a load and keep their value after draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) data_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) data_q[k] <= in_data;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = data_q[g];
        assign out_valid[g]                 = (state[g] == ST_FULL);
    end

    assign busy = |state;

`ifdef DEMUX_8BIT_XFER_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];

    // Counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (drain[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign xfer_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_demux_8bit_1x4_reg.sv
// Self-checking bench for demux_8bit_1x4_reg: queue-based channel model compared every
// cycle, plus directed literal expectations for each scenario.
module tb_demux_8bit_1x4_reg;

    localparam int DATA_W = 8;
`ifdef DEMUX_8BIT_XFER_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic                clk;
    logic                rst_n;
    logic [DATA_W-1:0]   in_data;
    logic [1:0]          in_sel;
    logic                in_valid;
    logic                in_ready;
    logic [4*DATA_W-1:0] out_data;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
    logic                busy;
`ifdef DEMUX_8BIT_XFER_CNT_EN
    logic [4*CNT_W-1:0]  xfer_cnt;
`endif

    int total = 0;
    int bad   = 0;

    demux_8bit_1x4_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef DEMUX_8BIT_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel is a queue of at most one word; last_word remembers what the
    // register shows once drained.
    logic [7:0] mq [4][$];
    logic [7:0] last_word [4];

    function automatic logic model_ready();
        return (mq[in_sel].size() == 0) || out_ready[in_sel];
    endfunction

    initial begin
        for (int k = 0; k < 4; k++) last_word[k] = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    mq[k].delete();
                    last_word[k] = 8'h00;
                end
            end else begin
                logic acc;
                acc = in_valid && model_ready();
                for (int k = 0; k < 4; k++)
                    if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
                if (acc) begin
                    mq[in_sel].push_back(in_data);
                    last_word[in_sel] = in_data;
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("model_valid%0d", k), 64'(out_valid[k]), 64'(mq[k].size() != 0));
                check($sformatf("model_data%0d", k), 64'(out_data[k*8 +: 8]), 64'(last_word[k]));
            end
            check("model_busy", 64'(busy), 64'((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0));
            check("model_ready", 64'(in_ready), 64'(model_ready()));
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s, input logic [3:0] r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = r;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic routing, back-to-back, all consumers ready.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h11 * (i + 1)), 2'(i), 4'hF);
            @(negedge clk);
            check("route_in_ready", 64'(in_ready), 64'h1);
            if (i > 0) begin
                check("route_valid", 64'(out_valid), 64'(4'b0001 << (i - 1)));
                check("route_data", 64'(out_data[(i-1)*8 +: 8]), 64'(8'h11 * i));
            end
        end
        drive(1'b0, 8'h00, 2'd0, 4'hF);
        @(negedge clk);
        check("route_last_valid", 64'(out_valid), 64'h8);
        check("route_last_data", 64'(out_data[31:24]), 64'h44);

        // Stall isolation on channel 1.
        drive(1'b1, 8'h55, 2'd1, 4'b1101);
        @(negedge clk);
        check("stall_first_ready", 64'(in_ready), 64'h1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h66, 2'd1, 4'b1101);
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'h0);
            check("stall_hold_data", 64'(out_data[15:8]), 64'h55);
            check("stall_hold_valid", 64'(out_valid[1]), 64'h1);
        end
        drive(1'b1, 8'h66, 2'd1, 4'b1111);
        @(negedge clk);
        check("stall_release_ready", 64'(in_ready), 64'h1);
        drive(1'b1, 8'h77, 2'd3, 4'b1111);
        @(negedge clk);
        check("stall_ch1_data", 64'(out_data[15:8]), 64'h66);
        drive(1'b0, 8'h00, 2'd0, 4'b1111);
        @(negedge clk);
        check("stall_ch3_valid", 64'(out_valid), 64'h8);
        check("stall_ch3_data", 64'(out_data[31:24]), 64'h77);

        // Bypass refill on channel 0.
        drive(1'b1, 8'h01, 2'd0, 4'b0000);
        drive(1'b1, 8'h02, 2'd0, 4'b0001);
        @(negedge clk);
        check("bypass_ready", 64'(in_ready), 64'h1);
        check("bypass_old_data", 64'(out_data[7:0]), 64'h01);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        @(negedge clk);
        check("bypass_valid", 64'(out_valid[0]), 64'h1);
        check("bypass_new_data", 64'(out_data[7:0]), 64'h02);
        drive(1'b0, 8'h00, 2'd0, 4'b1111);

        // Fill all four, then drain them together.
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hA0 + i), 2'(i), 4'b0000);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        @(negedge clk);
        check("fill_valid", 64'(out_valid), 64'hF);
        check("fill_data", 64'(out_data), 64'hA3A2A1A0);
        check("fill_busy", 64'(busy), 64'h1);
        drive(1'b0, 8'h00, 2'd0, 4'b1111);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        @(negedge clk);
        check("drain_valid", 64'(out_valid), 64'h0);
        check("drain_busy", 64'(busy), 64'h0);
        check("drain_data_kept", 64'(out_data), 64'hA3A2A1A0);

        // Asynchronous reset with channel 2 full.
        drive(1'b1, 8'hA5, 2'd2, 4'b0000);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        @(negedge clk);
        check("pre_reset_valid", 64'(out_valid), 64'h4);
        check("pre_reset_data", 64'(out_data[23:16]), 64'hA5);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'h0);
        check("async_reset_data", 64'(out_data), 64'h0);
        check("async_reset_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef DEMUX_8BIT_XFER_CNT_EN
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hC0 + i), 2'd3, 4'b1000);
        drive(1'b0, 8'h00, 2'd0, 4'b1000);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        @(negedge clk);
        check("xfer_cnt_sat", 64'(xfer_cnt), 64'(8'b11_00_00_00));
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
